inst_fetch_unit: RTL
====================

// Module: inst_fetch_unit
// PURPOSE
//  Instruction-fetch front end directly upstream of the instruction cache (cache_v2).
//  Holds the PC and issues fetch commands (command=1) against the cache's single-cycle hit path.
//  On a miss it waits for the cache's refill handshake.
//  Fetched {pc, inst} pairs are buffered in a small FIFO toward decode, with valid/ready backpressure.
//  Decode/execute redirects flush all fetch state.
// PARAMETERS
//  RESET_PC    32'h0  PC loaded on reset (word aligned)
//  FIFO_DEPTH  2      output FIFO entries (power of 2, >=2)
// PORTS
//  clk               in   1   clock, all state on posedge
//  rst               in   1   asynchronous, active-high reset
//  redirect_valid    in   1   flush and restart fetch at redirect_pc
//  redirect_pc       in   32  new PC; bits [1:0] ignored (treated as 0)
//  out_valid         out  1   FIFO head valid
//  out_ready         in   1   decode accepts head
//  out_pc            out  32  PC of head entry
//  out_inst          out  32  instruction of head entry
//  cache_command     out  3   0=idle, 1=read instruction; no other codes driven
//  cache_inst_addr   out  32  fetch address (= pc, bits [1:0]=0)
//  cache_ready       in   1   cache idle / accepting
//  cache_hit         in   1   combinational hit for current command=1
//  cache_inst_rdata_cache in 32  combinational hit data
//  cache_inst_rdata  in   32  registered data valid when cache returns to ready after miss
//  cache_error       in   2   nonzero = cache/AXI error
//  fetch_error       out  1   sticky error flag
// BEHAVIOUR
//  Reset: pc=RESET_PC, FIFO empty, state=FETCH, kill=0, seen_busy=0.
//   Outputs: out_valid=0, out_pc=0, out_inst=0, cache_command=0, fetch_error=0.
//  out_pc/out_inst read 0 whenever the FIFO is empty.
//  States: FETCH, MISS_WAIT, ERROR.
//  FETCH: issue when count<FIFO_DEPTH (registered count), cache_ready=1, redirect_valid=0, and cache_error=0.
//   Issue drives cache_command=1 and cache_inst_addr=pc. Otherwise cache_command=0.
//   - Issue && cache_hit: push {pc, cache_inst_rdata_cache}; pc+=4 (wraps mod 2^32). Zero-latency, one inst/cycle.
//   - Issue && !cache_hit: the cache latches the miss. Set miss_pc=pc, seen_busy=0, kill=0; go to MISS_WAIT.
//  MISS_WAIT: cache_command=0.
//   - cache_ready=0 sets seen_busy.
//   - Completion is the first cycle with seen_busy=1 && cache_ready=1.
//   - At completion with kill=0: push {miss_pc, cache_inst_rdata}; pc=miss_pc+4; go to FETCH.
//   - At completion with kill=1: discard the data; pc=pending redirect pc (already loaded); go to FETCH.
//   - FIFO has room: the state is entered only with count<FIFO_DEPTH, and nothing else pushes during it.
//  Redirect (any state except ERROR): highest priority.
//   - FIFO flushed (count=0) at the edge; out_valid=0 the next cycle; a same-cycle pop is ignored.
//   - pc=redirect_pc & ~3.
//   - In FETCH, no command is issued that cycle.
//   - In MISS_WAIT, set kill=1 and stay until completion; the last redirect wins.
//   - A redirect in the completion cycle also sets kill.
//  FIFO: pop on out_valid&&out_ready.
//   - Push and pop in the same cycle leave count unchanged.
//   - Push is never attempted when count==FIFO_DEPTH.
//  Error: cache_error!=0 in any state -> ERROR at the next edge.
//   - In ERROR: fetch_error=1, cache_command=0, redirects ignored, FIFO still drains.
//   - Exit only by rst.
//  rst asserted mid-miss: immediate return to reset values. The cache side is not reset by this block.
// TESTING
//  1. RESET_PC=0, all hits, out_ready=1 -> commands at 0x0,0x4,0x8; out_pc 0x0,0x4,0x8 one per cycle; out_valid from cycle after first issue.
//  2. Miss at 0x40: hit=0, ready low 20 cycles, then high with cache_inst_rdata=0xDEADBEEF -> single entry {0x40,0xDEADBEEF}; next command addr 0x44; command=0 throughout wait.
//  3. out_ready=0 with all hits -> exactly FIFO_DEPTH pushes (0x0,0x4), then command=0, pc=0x8 held; out_ready=1 -> 0x0,0x4,0x8 in order, no loss or duplicate.
//  4. Redirect to 0x103 during a MISS_WAIT at 0x80 -> miss data discarded; first command after completion at 0x100; no entry with pc 0x80.
//  5. FIFO full, redirect_valid and out_ready asserted the same cycle -> out_valid=0 next cycle; next push has pc 0x100 (the redirect target).
//  6. cache_error=1 mid-stream -> fetch_error=1 next cycle, command stays 0, redirect ignored; async rst mid-miss -> outputs at reset values without waiting for clk.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: PC sequencing against the instruction cache hit path,
// miss refill wait, redirect flush, and a small {pc, inst} FIFO toward decode.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [2:0]  cache_command,
  output logic [31:0] cache_inst_addr,
  input  logic        cache_ready,
  input  logic        cache_hit,
  input  logic [31:0] cache_inst_rdata_cache,
  input  logic [31:0] cache_inst_rdata,
  input  logic [1:0]  cache_error,
  output logic        fetch_error
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {FETCH, MISS_WAIT, ERROR} state_t;

  state_t         state;
  logic [31:0]    pc;
  logic [31:0]    miss_pc;
  logic           kill;
  logic           seen_busy;
  logic [31:0]    fifo_pc   [FIFO_DEPTH];
  logic [31:0]    fifo_inst [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  logic        cache_err;
  logic        issue;
  logic        complete;
  logic        push;
  logic        pop;
  logic        flush;
  logic [31:0] push_pc;
  logic [31:0] push_inst;
  logic [31:0] redirect_aligned;

  assign cache_err        = |cache_error;
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  // Registered count gates issue so a full FIFO never issues, even when popping this cycle.
  assign issue    = !rst && (state == FETCH) && (count < CW'(FIFO_DEPTH)) && cache_ready
                    && !redirect_valid && !cache_err;
  assign complete = (state == MISS_WAIT) && seen_busy && cache_ready;
  assign flush    = redirect_valid && (state != ERROR) && !cache_err;
  assign push     = !cache_err && ((issue && cache_hit) || (complete && !kill && !redirect_valid));
  assign push_pc   = (state == MISS_WAIT) ? miss_pc : pc;
  assign push_inst = (state == MISS_WAIT) ? cache_inst_rdata : cache_inst_rdata_cache;
  assign pop       = out_valid && out_ready;

  assign out_valid       = (count != '0);
  assign out_pc          = out_valid ? fifo_pc[rd_ptr]   : 32'h0;
  assign out_inst        = out_valid ? fifo_inst[rd_ptr] : 32'h0;
  assign cache_command   = issue ? 3'd1 : 3'd0;
  assign cache_inst_addr = pc;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= push_pc;
      fifo_inst[wr_ptr] <= push_inst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      miss_pc     <= RESET_PC;
      kill        <= 1'b0;
      seen_busy   <= 1'b0;
      fetch_error <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end

      case (state)
        FETCH: begin
          if (cache_err) begin
            state       <= ERROR;
            fetch_error <= 1'b1;
          end else if (redirect_valid) begin
            pc <= redirect_aligned;
          end else if (issue) begin
            if (cache_hit) begin
              pc <= pc + 32'd4;
            end else begin
              miss_pc   <= pc;
              seen_busy <= 1'b0;
              kill      <= 1'b0;
              state     <= MISS_WAIT;
            end
          end
        end
        MISS_WAIT: begin
          if (cache_err) begin
            state       <= ERROR;
            fetch_error <= 1'b1;
          end else begin
            if (!cache_ready) seen_busy <= 1'b1;
            if (redirect_valid) pc <= redirect_aligned;
            // A killed refill leaves pc at the last redirect target.
            if (complete) begin
              state <= FETCH;
              if (!kill && !redirect_valid) pc <= miss_pc + 32'd4;
            end else if (redirect_valid) begin
              kill <= 1'b1;
            end
          end
        end
        default: begin
          state       <= ERROR;
          fetch_error <= 1'b1;
        end
      endcase
    end
  end

endmodule
